imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction-fetch sequencer for the pipeline's combinational, byte-addressed, big-endian instruction memory (32-bit words, zero/NOP returned out of range). Owns the program counter, drives the memory address, captures each fetched word with its PC into a small flushable buffer, and presents it to the IF/ID register over a valid/ready handshake. Handles branch/jump redirects, halt, and optional fetch-fault detection.

## Interface

- PC_W, 32, PC and address width
- MEM_BYTES, 400, instruction memory size in bytes
- RESET_PC, 0, PC loaded at reset
- BUF_DEPTH, 2, fetch buffer entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_addr  out  PC_W  address to instruction memory, equals current PC register
- imem_data  in  32  combinational word returned for imem_addr
- redirect_valid  in  1  load redirect_pc and flush
- redirect_pc  in  PC_W  branch/jump target
- halt  in  1  suppress new fetches; buffered words still drain
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  IF/ID accepts head
- inst_out  out  32  head instruction
- inst_pc  out  PC_W  head PC
- inst_pc4  out  PC_W  head PC + 4, modulo 2^PC_W
- fetch_fault  out  1  sticky fault flag
- fault_pc  out  PC_W  PC that caused the fault

## Operation

- pop = inst_valid & inst_ready; head dequeued at edge.
- fetch = !halt & !fault & !redirect_valid & (count < BUF_DEPTH | pop).
- On fetch: enqueue {pc, imem_data}; pc <= pc + 4 (wraps modulo 2^PC_W, no flag).
- Redirect (highest priority): pc <= redirect_pc; buffer flushed (count=0, pointers 0); no enqueue that edge; a same-cycle pop completes, then everything is discarded; fetch_fault cleared.
- Simultaneous pop and enqueue with full buffer: count unchanged, both pointers advance.
- Empty buffer: inst_valid=0, inst_out=0 (NOP), inst_pc/inst_pc4 = 0.
- halt: pc frozen, no enqueue; pops continue; deasserting resumes at frozen pc.
- Pointers wrap modulo BUF_DEPTH; count range 0..BUF_DEPTH.
- Reset values: pc=RESET_PC (so imem_addr=RESET_PC), count=0, inst_valid=0, inst_out=0, inst_pc=0, inst_pc4=0, fetch_fault=0, fault_pc=0. Reset mid-operation discards buffer immediately (asynchronous).

## Timing

- imem_addr is a register output; memory read is combinational within the same cycle.
- Reset release → first word enqueued at first edge → inst_valid high after edge 1.
- Redirect sampled at edge N → target word valid after edge N+1 (one bubble cycle).
- Steady state with inst_ready=1: one instruction per cycle, PCs consecutive by 4.
- inst_ready low with buffer full: fetch stalls, pc held, no words lost or duplicated.

## Configuration

- IMEM_FETCH_BOUNDS_CHECK_EN defined: a fetch whose pc[1:0]≠0 or pc > MEM_BYTES−4 is not enqueued; fetch_fault←1, fault_pc←pc, fetching stops until redirect; buffered words drain normally.
- Undefined: no checks; fetch_fault and fault_pc tied 0; misaligned PCs read four consecutive bytes; out-of-range PCs enqueue 32'h0 (NOP) as returned by memory.

## Structure

- Package imem_pkg: INST_W=32, NOP_INST=32'h0, PC width default, typedef struct fetch_entry_t {pc, inst}.
- One sub-module: fetch_buf — BUF_DEPTH-entry FIFO of fetch_entry_t with push, pop, synchronous flush, count, full/empty.
- Top holds PC register, fetch/redirect/halt logic, fault logic.

## Test plan

- Reset release, RESET_PC=0, inst_ready=1, memory holding words at 0,4,8 → inst_valid after edge 1, inst_pc sequence 0,4,8, inst_pc4 4,8,12.
- inst_ready=0 for 5 cycles → exactly 2 entries (PC 0,4), imem_addr holds 8; ready=1 → 0,4,8 delivered, no gaps or repeats.
- redirect_valid with redirect_pc=0x40 while buffer holds 2 entries → buffer emptied next cycle, inst_pc=0x40 valid after one bubble.
- halt=1 at pc=0x10 with 2 buffered → both drain, then inst_valid=0, imem_addr stays 0x10; halt=0 → 0x10 delivered.
- With IMEM_FETCH_BOUNDS_CHECK_EN, redirect to 0x192 (misaligned) → fetch_fault=1, fault_pc=0x192, no enqueue; redirect to 0x0 clears it; reaching pc=0x190 (400) faults with fault_pc=0x190.
- Without macro, pc reaching 0x190 → inst_out=0 (NOP) delivered, fetch_fault stays 0; rst asserted mid-stream → inst_valid=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_pkg;

    localparam int INST_W       = 32;
    localparam int PC_W_DEFAULT = 32;

    localparam logic [INST_W-1:0] NOP_INST = '0;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0] pc;
        logic [INST_W-1:0]       inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small flushable FIFO of fetched {pc, inst} entries; an empty head reads as all-zero (NOP at PC 0).
module fetch_buf
    import imem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A pop frees a slot in the same edge, so a full buffer can still accept a push.
    assign push_ok = push & (~full | pop) & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_entry;
    end

    assign head_entry = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, redirect/halt control and a fetch buffer toward IF/ID.
// Optional fetch-fault bounds checking is enabled by defining IMEM_FETCH_BOUNDS_CHECK_EN.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              MEM_BYTES = 400,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   inst_pc,
    output logic [PC_W-1:0]   inst_pc4,
    output logic              fetch_fault,
    output logic [PC_W-1:0]   fault_pc
);

    // Reject configurations the buffer and bounds logic cannot support.
    if (MEM_BYTES < 4 || BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0
        || PC_W > PC_W_DEFAULT) begin : g_cfg_err
        $error("imem_fetch_ctrl: unsupported MEM_BYTES/BUF_DEPTH/PC_W");
    end

    logic [PC_W-1:0]                pc_reg, pc_next;
    logic                           pop;
    logic                           fetch_en;
    fetch_entry_t                   push_entry;
    fetch_entry_t                   head_entry;
    logic [$clog2(BUF_DEPTH+1)-1:0] buf_count;
    logic                           buf_full;
    logic                           buf_empty;

    assign pop = inst_valid & inst_ready;

`ifdef IMEM_FETCH_BOUNDS_CHECK_EN
    localparam logic [PC_W-1:0] LAST_WORD_ADDR = PC_W'(MEM_BYTES - 4);

    logic            fault_reg;
    logic [PC_W-1:0] fault_pc_reg;
    logic            fetch_try;
    logic            addr_bad;
    logic            fault_set;

    assign addr_bad  = (pc_reg[1:0] != 2'b00) || (pc_reg > LAST_WORD_ADDR);
    assign fetch_try = ~halt & ~fault_reg & ~redirect_valid & (~buf_full | pop);
    assign fetch_en  = fetch_try & ~addr_bad;
    assign fault_set = fetch_try & addr_bad;

    // fault_pc keeps the last offending PC after a redirect clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_reg    <= 1'b0;
            fault_pc_reg <= '0;
        end else if (redirect_valid) begin
            fault_reg    <= 1'b0;
        end else if (fault_set) begin
            fault_reg    <= 1'b1;
            fault_pc_reg <= pc_reg;
        end
    end

    assign fetch_fault = fault_reg;
    assign fault_pc    = fault_pc_reg;
`else
    assign fetch_en    = ~halt & ~redirect_valid & (~buf_full | pop);
    assign fetch_fault = 1'b0;
    assign fault_pc    = '0;
`endif

    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (fetch_en) begin
            pc_next = pc_reg + PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign imem_addr       = pc_reg;
    assign push_entry.pc   = PC_W_DEFAULT'(pc_reg);
    assign push_entry.inst = imem_data;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (fetch_en),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    assign inst_valid = ~buf_empty;
    assign inst_out   = buf_empty ? NOP_INST : head_entry.inst;
    assign inst_pc    = PC_W'(head_entry.pc);
    assign inst_pc4   = buf_empty ? '0 : PC_W'(head_entry.pc) + PC_W'(4);

endmodule
